fir_coeff_seq_ctrl: RTL and testbench

//  Sequences software FIR coefficient updates for the chan_512_packet channelizer.

---
 rtl/fir_coeff_seq_ctrl_pkg.sv | 45 ++++
 rtl/fir_coeff_seq_ctrl_if.sv | 35 +++
 rtl/fir_coeff_seq_ctrl_toggle_edge_det.sv | 27 ++
 rtl/fir_coeff_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fir_coeff_seq_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_coeff_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_coeff_seq_ctrl_pkg
// Shared definitions for the FIR coefficient update sequencer:
//   - command-word bit positions (write toggle, commit toggle)
//   - status-word field offsets and a packing helper
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package fir_coeff_seq_ctrl_pkg;

   // Command word bit positions
   localparam int CMD_WR_BIT  = 31;
   localparam int CMD_CMT_BIT = 30;

   // Status word field offsets
   localparam int STAT_BANK_BIT = 31;
   localparam int STAT_PEND_BIT = 30;
   localparam int STAT_BUSY_BIT = 29;
   localparam int STAT_ERR_BIT  = 28;
   localparam int STAT_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_EVEN = 2'd1,
      ST_WR_ODD  = 2'd2
   } fsm_state_e;

   // Assemble the software-visible status word; unused middle bits read as zero.
   function automatic logic [31:0] pack_status(
      input logic                  bank,
      input logic                  pend,
      input logic                  busy,
      input logic                  err,
      input logic [STAT_CNT_W-1:0] cnt
   );
      logic [31:0] word_s;
      word_s                   = 32'd0;
      word_s[STAT_BANK_BIT]    = bank;
      word_s[STAT_PEND_BIT]    = pend;
      word_s[STAT_BUSY_BIT]    = busy;
      word_s[STAT_ERR_BIT]     = err;
      word_s[STAT_CNT_W-1:0]   = cnt;
      return word_s;
   endfunction

endpackage

// File: rtl/fir_coeff_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// fir_coeff_seq_ctrl_if
// Register-side inputs and coefficient-RAM-side outputs of the sequencer.
//   cmd_word    : [31] write toggle, [30] commit toggle, [TAP_AW-2:0] pair addr
//   coeff_word  : [16+COEF_W-1:16] even coef, [COEF_W-1:0] odd coef
//   sync_in     : channelizer frame sync
//   coef_we/coef_bank/coef_addr/coef_data : coefficient RAM write port
//   bank_sel    : bank the FIR reads
//   status_word : {bank_sel, swap_pending, busy, err, 12'b0, wr_count}
// master = register/system side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface fir_coeff_seq_ctrl_if #(
   parameter int TAP_AW = 4,
   parameter int COEF_W = 16
) ();
   logic [31:0]       cmd_word;
   logic [31:0]       coeff_word;
   logic              sync_in;
   logic              coef_we;
   logic              coef_bank;
   logic [TAP_AW-1:0] coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              bank_sel;
   logic [31:0]       status_word;

   modport master (
      output cmd_word, coeff_word, sync_in,
      input  coef_we, coef_bank, coef_addr, coef_data, bank_sel, status_word
   );

   modport slave (
      input  cmd_word, coeff_word, sync_in,
      output coef_we, coef_bank, coef_addr, coef_data, bank_sel, status_word
   );
endinterface

// File: rtl/fir_coeff_seq_ctrl_toggle_edge_det.sv
// -----------------------------------------------------------------------------
// fir_coeff_seq_ctrl_toggle_edge_det
// Turns software toggle bits into one-cycle event pulses.
//   clk      : clock
//   rst      : synchronous active-high reset
//   tog_bits : live toggle bits {write, commit}
//   evt      : event pulses, high in the cycle a toggle bit changes
// -----------------------------------------------------------------------------
module fir_coeff_seq_ctrl_toggle_edge_det (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] tog_bits,
   output logic [1:0] evt
);
   logic [1:0] ref_r;

   // Reference follows the toggle bits; during reset it preloads the live value so release is edge-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_r <= tog_bits;
      end else begin
         ref_r <= tog_bits;
      end
   end

   assign evt = tog_bits ^ ref_r;
endmodule

// File: rtl/fir_coeff_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fir_coeff_seq_ctrl
// Decodes software command/coefficient registers into paired tap writes on the
// inactive FIR coefficient bank and swaps banks on the frame sync after commit.
//   OPB_Clk : clock
//   OPB_Rst : synchronous active-high reset
//   bus     : register inputs and RAM-side outputs (see fir_coeff_seq_ctrl_if)
// -----------------------------------------------------------------------------
module fir_coeff_seq_ctrl
   import fir_coeff_seq_ctrl_pkg::*;
#(
   parameter int TAP_AW = 4,
   parameter int COEF_W = 16
) (
   input  logic                 OPB_Clk,
   input  logic                 OPB_Rst,
   fir_coeff_seq_ctrl_if.slave  bus
);
   localparam int PAIR_W = TAP_AW - 1;

   fsm_state_e        state_r;
   fsm_state_e        state_nxt_s;
   logic [1:0]        evt_s;
   logic              wr_evt_s;
   logic              cmt_evt_s;
   logic              accept_s;
   logic              reject_s;
   logic [PAIR_W-1:0] pair_in_s;
   logic [COEF_W-1:0] even_in_s;
   logic [COEF_W-1:0] odd_in_s;
   logic [PAIR_W-1:0] pair_r;
   logic [COEF_W-1:0] odd_r;
   logic              coef_we_nxt_s;
   logic [TAP_AW-1:0] coef_addr_nxt_s;
   logic [COEF_W-1:0] coef_data_nxt_s;
   logic              coef_we_r;
   logic [TAP_AW-1:0] coef_addr_r;
   logic [COEF_W-1:0] coef_data_r;
   logic              busy_r;
   logic              err_r;
   logic [15:0]       wr_count_r;
   logic              cmt_req_r;
   logic              swap_pending_r;
   logic              bank_sel_r;
   logic              unused_s;

   fir_coeff_seq_ctrl_toggle_edge_det u_edge (
      .clk      (OPB_Clk),
      .rst      (OPB_Rst),
      .tog_bits ({bus.cmd_word[CMD_WR_BIT], bus.cmd_word[CMD_CMT_BIT]}),
      .evt      (evt_s)
   );

   assign wr_evt_s  = evt_s[1];
   assign cmt_evt_s = evt_s[0];
   assign pair_in_s = bus.cmd_word[PAIR_W-1:0];
   assign even_in_s = bus.coeff_word[16+COEF_W-1:16];
   assign odd_in_s  = bus.coeff_word[COEF_W-1:0];
   // Most command/coefficient bits carry no meaning here.
   assign unused_s  = ^{bus.cmd_word, bus.coeff_word};

   // The shadow bank is frozen once a swap is pending, so writes are refused then too.
   assign accept_s = (state_r == ST_IDLE) && wr_evt_s && !swap_pending_r;
   assign reject_s = wr_evt_s && (busy_r || swap_pending_r);

   // FSM state register.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_WR_EVEN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WR_EVEN: state_nxt_s = ST_WR_ODD;
         ST_WR_ODD:  state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output decode from the next state so the RAM port is registered without extra latency.
   always_comb begin
      coef_we_nxt_s   = 1'b0;
      coef_addr_nxt_s = coef_addr_r;
      coef_data_nxt_s = coef_data_r;
      case (state_nxt_s)
         ST_WR_EVEN: begin
            // Entering from IDLE: the pair is still on the live inputs.
            coef_we_nxt_s   = 1'b1;
            coef_addr_nxt_s = {pair_in_s, 1'b0};
            coef_data_nxt_s = even_in_s;
         end
         ST_WR_ODD: begin
            coef_we_nxt_s   = 1'b1;
            coef_addr_nxt_s = {pair_r, 1'b1};
            coef_data_nxt_s = odd_r;
         end
         default: begin
            coef_we_nxt_s   = 1'b0;
            coef_addr_nxt_s = coef_addr_r;
            coef_data_nxt_s = coef_data_r;
         end
      endcase
   end

   // RAM port, capture, busy, error and write-count registers.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         coef_we_r   <= 1'b0;
         coef_addr_r <= {TAP_AW{1'b0}};
         coef_data_r <= {COEF_W{1'b0}};
         pair_r      <= {PAIR_W{1'b0}};
         odd_r       <= {COEF_W{1'b0}};
         busy_r      <= 1'b0;
         err_r       <= 1'b0;
         wr_count_r  <= 16'd0;
      end else begin
         coef_we_r   <= coef_we_nxt_s;
         coef_addr_r <= coef_addr_nxt_s;
         coef_data_r <= coef_data_nxt_s;
         busy_r      <= (state_nxt_s != ST_IDLE);
         if (accept_s) begin
            pair_r <= pair_in_s;
            odd_r  <= odd_in_s;
         end
         if (reject_s) begin
            err_r <= 1'b1;
         end
         if (state_r == ST_WR_ODD) begin
            wr_count_r <= wr_count_r + 16'd1;
         end
      end
   end

   // Commit request, swap-pending and bank-select tracking.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         cmt_req_r      <= 1'b0;
         swap_pending_r <= 1'b0;
         bank_sel_r     <= 1'b0;
      end else begin
         // A request only becomes pending between writes, so an in-flight pair always lands first.
         if ((state_r == ST_IDLE) && cmt_req_r) begin
            cmt_req_r      <= 1'b0;
            swap_pending_r <= 1'b1;
         end else if (cmt_evt_s && !cmt_req_r && !swap_pending_r) begin
            cmt_req_r <= 1'b1;
         end
         // Pending and request are mutually exclusive, so this never collides with the set above.
         if (bus.sync_in && swap_pending_r) begin
            bank_sel_r     <= ~bank_sel_r;
            swap_pending_r <= 1'b0;
         end
      end
   end

   assign bus.coef_we     = coef_we_r;
   assign bus.coef_addr   = coef_addr_r;
   assign bus.coef_data   = coef_data_r;
   assign bus.bank_sel    = bank_sel_r;
   assign bus.coef_bank   = ~bank_sel_r;
   assign bus.status_word = pack_status(bank_sel_r, swap_pending_r, busy_r, err_r, wr_count_r);
endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_seq_ctrl
// Directed scenarios followed by randomized traffic, all compared each cycle
// against a queue-based behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_fir_coeff_seq_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fir_coeff_seq_ctrl_if #(.TAP_AW(4), .COEF_W(16)) bus ();

   fir_coeff_seq_ctrl #(.TAP_AW(4), .COEF_W(16)) dut (
      .OPB_Clk (clk),
      .OPB_Rst (rst),
      .bus     (bus)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;

   // Behavioural model state: values visible during the current cycle.
   logic        m_we;
   logic [3:0]  m_addr;
   logic [15:0] m_data;
   logic        m_bank;
   logic        m_pend;
   logic        m_req;
   logic        m_busy;
   logic        m_err;
   logic [15:0] m_cnt;
   logic [1:0]  m_prev;
   wr_t         m_q[$];

   logic [31:0] cur_cmd;
   logic [31:0] cur_coef;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model across one clock edge using the inputs held during that cycle.
   task automatic model_step(input logic [31:0] cmd, input logic [31:0] cf, input logic sy, input logic rs);
      logic wr;
      logic cm;
      logic idle;
      logic nxt_pend;
      logic nxt_bank;
      wr_t  w;
      if (rs) begin
         m_we = 1'b0; m_addr = 4'd0; m_data = 16'd0; m_bank = 1'b0; m_pend = 1'b0;
         m_req = 1'b0; m_busy = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
         m_prev = cmd[31:30];
         m_q.delete();
         return;
      end
      wr = cmd[31] ^ m_prev[1];
      cm = cmd[30] ^ m_prev[0];
      m_prev = cmd[31:30];
      idle = !m_busy;
      nxt_pend = m_pend;
      nxt_bank = m_bank;
      if (wr && (m_busy || m_pend)) m_err = 1'b1;
      if (wr && idle && !m_pend) begin
         m_q.push_back('{addr: {cmd[2:0], 1'b0}, data: cf[31:16]});
         m_q.push_back('{addr: {cmd[2:0], 1'b1}, data: cf[15:0]});
      end
      if (idle && m_req) begin
         m_req = 1'b0;
         nxt_pend = 1'b1;
      end else if (cm && !m_req && !m_pend) begin
         m_req = 1'b1;
      end
      if (sy && m_pend) begin
         nxt_bank = ~m_bank;
         nxt_pend = 1'b0;
      end
      // A pair completes in the cycle its odd tap is written.
      if (m_we && m_addr[0]) m_cnt = m_cnt + 16'd1;
      if (m_q.size() > 0) begin
         w = m_q.pop_front();
         m_we = 1'b1; m_addr = w.addr; m_data = w.data;
      end else begin
         m_we = 1'b0;
      end
      m_busy = m_we;
      m_pend = nxt_pend;
      m_bank = nxt_bank;
   endtask

   task automatic compare_all();
      check_val("coef_we",   {31'd0, bus.coef_we},   {31'd0, m_we});
      check_val("coef_addr", {28'd0, bus.coef_addr}, {28'd0, m_addr});
      check_val("coef_data", {16'd0, bus.coef_data}, {16'd0, m_data});
      check_val("bank_sel",  {31'd0, bus.bank_sel},  {31'd0, m_bank});
      check_val("coef_bank", {31'd0, bus.coef_bank}, {31'd0, ~m_bank});
      check_val("status",    bus.status_word, {m_bank, m_pend, m_busy, m_err, 12'd0, m_cnt});
   endtask

   task automatic cycle(input logic sy, input logic rs);
      bus.cmd_word   = cur_cmd;
      bus.coeff_word = cur_coef;
      bus.sync_in    = sy;
      rst            = rs;
      @(posedge clk);
      model_step(cur_cmd, cur_coef, sy, rs);
      #1;
      compare_all();
   endtask

   // Stimulus sequence.
   initial begin
      logic [31:0] st;
      checks = 0;
      errors = 0;
      m_q.delete();

      // 1: reset with both toggle bits set, release must not produce a write
      cur_cmd  = 32'hC000_0000;
      cur_coef = 32'd0;
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0);
         check_val("t1_we", {31'd0, bus.coef_we}, 32'd0);
         check_val("t1_status", bus.status_word, 32'd0);
      end

      // 2: single pair write to address 3
      cur_coef = 32'h1234_ABCD;
      cur_cmd  = 32'h4000_0003;
      cycle(1'b0, 1'b0);
      check_val("t2_even", {bus.coef_we, bus.coef_bank, 10'd0, bus.coef_addr, bus.coef_data},
                {1'b1, 1'b1, 10'd0, 4'd6, 16'h1234});
      cycle(1'b0, 1'b0);
      check_val("t2_odd", {bus.coef_we, bus.coef_bank, 10'd0, bus.coef_addr, bus.coef_data},
                {1'b1, 1'b1, 10'd0, 4'd7, 16'hABCD});
      cycle(1'b0, 1'b0);
      check_val("t2_we_off", {31'd0, bus.coef_we}, 32'd0);
      check_val("t2_count", {16'd0, bus.status_word[15:0]}, 32'd1);

      // 3: commit, sync five cycles later
      cur_cmd = 32'h0000_0003;
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);
      check_val("t3_pending", {31'd0, bus.status_word[30]}, 32'd1);
      check_val("t3_bank_hold", {31'd0, bus.bank_sel}, 32'd0);
      cycle(1'b1, 1'b0);
      check_val("t3_bank_sel", {31'd0, bus.bank_sel}, 32'd1);
      check_val("t3_coef_bank", {31'd0, bus.coef_bank}, 32'd0);
      check_val("t3_pend_clr", {31'd0, bus.status_word[30]}, 32'd0);

      // 4: write while a swap is pending is refused
      cur_cmd = 32'h4000_0003;
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      check_val("t4_pending", {31'd0, bus.status_word[30]}, 32'd1);
      cur_cmd = 32'hC000_0003;
      cycle(1'b0, 1'b0);
      check_val("t4_no_we", {31'd0, bus.coef_we}, 32'd0);
      check_val("t4_err", {31'd0, bus.status_word[28]}, 32'd1);
      cycle(1'b0, 1'b0);
      check_val("t4_no_we2", {31'd0, bus.coef_we}, 32'd0);
      check_val("t4_count", {16'd0, bus.status_word[15:0]}, 32'd1);
      cycle(1'b1, 1'b0);
      check_val("t4_swap_back", {31'd0, bus.bank_sel}, 32'd0);

      // 5: write and commit together, sync every cycle
      cur_cmd  = 32'h0000_0005;
      cur_coef = 32'h5A5A_0F0F;
      cycle(1'b1, 1'b0);
      check_val("t5_even", {bus.coef_we, 11'd0, bus.coef_addr, bus.coef_data}, {1'b1, 11'd0, 4'd10, 16'h5A5A});
      cycle(1'b1, 1'b0);
      check_val("t5_odd", {bus.coef_we, 11'd0, bus.coef_addr, bus.coef_data}, {1'b1, 11'd0, 4'd11, 16'h0F0F});
      cycle(1'b1, 1'b0);
      check_val("t5_idle", {29'd0, bus.coef_we, bus.status_word[30], bus.bank_sel}, 32'd0);
      cycle(1'b1, 1'b0);
      check_val("t5_pend", {30'd0, bus.status_word[30], bus.bank_sel}, 32'd2);
      cycle(1'b1, 1'b0);
      check_val("t5_swap", {30'd0, bus.status_word[30], bus.bank_sel}, 32'd1);
      check_val("t5_count", {16'd0, bus.status_word[15:0]}, 32'd2);
      cycle(1'b0, 1'b0);

      // 6: reset during the even write aborts the pair
      cur_cmd  = 32'h8000_0002;
      cur_coef = 32'hBEEF_CAFE;
      cycle(1'b0, 1'b0);
      check_val("t6_even", {31'd0, bus.coef_we}, 32'd1);
      cycle(1'b0, 1'b1);
      check_val("t6_we_rst", {31'd0, bus.coef_we}, 32'd0);
      check_val("t6_status", bus.status_word, 32'd0);
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0);
         check_val("t6_no_odd", {31'd0, bus.coef_we}, 32'd0);
      end

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         st = $urandom;
         cur_cmd[29:0] = st[29:0];
         if ($urandom_range(0, 5) == 0) cur_cmd[31] = ~cur_cmd[31];
         if ($urandom_range(0, 9) == 0) cur_cmd[30] = ~cur_cmd[30];
         cur_coef = $urandom;
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
